// File: rtl/f_scheduler.sv
// Round-robin time-share of one F permutation core between the absorb (port 0)
// and squeeze (port 1) engines, with a watchdog that aborts hung permutations.
module f_scheduler #(
  parameter int CWIDTH   = 320,
  parameter int RWIDTH   = 32,
  parameter int XWIDTH   = 64,
  parameter int IWIDTH   = 128,
  parameter int DSWIDTH  = 4,
  parameter int RNDWIDTH = 8,
  parameter int TIMEOUT  = 1024
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          req,
  input  logic [CWIDTH-1:0]   c0,
  input  logic [CWIDTH-1:0]   c1,
  input  logic [XWIDTH-1:0]   x0,
  input  logic [XWIDTH-1:0]   x1,
  input  logic [IWIDTH-1:0]   i0,
  input  logic [IWIDTH-1:0]   i1,
  input  logic [DSWIDTH-1:0]  ds0,
  input  logic [DSWIDTH-1:0]  ds1,
  input  logic [RNDWIDTH-1:0] rounds0,
  input  logic [RNDWIDTH-1:0] rounds1,
  input  logic [CWIDTH-1:0]   f_cout,
  input  logic [XWIDTH-1:0]   f_xout,
  input  logic [RWIDTH-1:0]   f_rout,
  input  logic                f_done,
  output logic [CWIDTH-1:0]   f_c,
  output logic [XWIDTH-1:0]   f_x,
  output logic [IWIDTH-1:0]   f_i,
  output logic [DSWIDTH-1:0]  f_ds,
  output logic [RNDWIDTH-1:0] f_rounds,
  output logic                f_rst,
  output logic [1:0]          gnt,
  output logic [1:0]          done,
  output logic [CWIDTH-1:0]   res_c,
  output logic [XWIDTH-1:0]   res_x,
  output logic [RWIDTH-1:0]   res_r,
  output logic                timeout,
  output logic                busy
);

  localparam int CNTW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_KICK,
    S_BUSY,
    S_RESP
  } state_t;

  state_t              state_q,    state_d;
  logic                last_q,     last_d;
  logic                win_q,      win_d;
  logic [CNTW-1:0]     cnt_q,      cnt_d;
  logic [1:0]          gnt_q,      gnt_d;
  logic [1:0]          done_q,     done_d;
  logic                timeout_q,  timeout_d;
  logic                busy_q,     busy_d;
  logic                f_rst_q,    f_rst_d;
  logic [CWIDTH-1:0]   f_c_q,      f_c_d;
  logic [XWIDTH-1:0]   f_x_q,      f_x_d;
  logic [IWIDTH-1:0]   f_i_q,      f_i_d;
  logic [DSWIDTH-1:0]  f_ds_q,     f_ds_d;
  logic [RNDWIDTH-1:0] f_rounds_q, f_rounds_d;
  logic [CWIDTH-1:0]   res_c_q,    res_c_d;
  logic [XWIDTH-1:0]   res_x_q,    res_x_d;
  logic [RWIDTH-1:0]   res_r_q,    res_r_d;

  logic win_sel;

  // On a tie the port that was not served last wins.
  always_comb begin
    win_sel = 1'b0;
    case (req)
      2'b01:   win_sel = 1'b0;
      2'b10:   win_sel = 1'b1;
      2'b11:   win_sel = ~last_q;
      default: win_sel = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    win_d      = win_q;
    cnt_d      = cnt_q;
    gnt_d      = gnt_q;
    done_d     = done_q;
    timeout_d  = timeout_q;
    busy_d     = busy_q;
    f_rst_d    = f_rst_q;
    f_c_d      = f_c_q;
    f_x_d      = f_x_q;
    f_i_d      = f_i_q;
    f_ds_d     = f_ds_q;
    f_rounds_d = f_rounds_q;
    res_c_d    = res_c_q;
    res_x_d    = res_x_q;
    res_r_d    = res_r_q;

    case (state_q)
      S_IDLE: begin
        if (req != 2'b00) begin
          win_d      = win_sel;
          f_c_d      = win_sel ? c1      : c0;
          f_x_d      = win_sel ? x1      : x0;
          f_i_d      = win_sel ? i1      : i0;
          f_ds_d     = win_sel ? ds1     : ds0;
          f_rounds_d = win_sel ? rounds1 : rounds0;
          gnt_d      = win_sel ? 2'b10   : 2'b01;
          busy_d     = 1'b1;
          f_rst_d    = 1'b1;
          state_d    = S_KICK;
        end
      end

      S_KICK: begin
        cnt_d   = '0;
        f_rst_d = 1'b0;
        state_d = S_BUSY;
      end

      // A core completion on the watchdog's final cycle still counts as success.
      S_BUSY: begin
        cnt_d = cnt_q + CNTW'(1);
        if (f_done) begin
          res_c_d   = f_cout;
          res_x_d   = f_xout;
          res_r_d   = f_rout;
          timeout_d = 1'b0;
          done_d    = gnt_q;
          f_rst_d   = 1'b1;
          state_d   = S_RESP;
        end else if (cnt_q == CNT_LAST) begin
          timeout_d = 1'b1;
          done_d    = gnt_q;
          f_rst_d   = 1'b1;
          state_d   = S_RESP;
        end
      end

      S_RESP: begin
        last_d    = win_q;
        gnt_d     = 2'b00;
        done_d    = 2'b00;
        timeout_d = 1'b0;
        busy_d    = 1'b0;
        f_rst_d   = 1'b1;
        state_d   = S_IDLE;
      end

      default: begin
        gnt_d     = 2'b00;
        done_d    = 2'b00;
        timeout_d = 1'b0;
        busy_d    = 1'b0;
        f_rst_d   = 1'b1;
        state_d   = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      last_q     <= 1'b1;
      win_q      <= 1'b0;
      cnt_q      <= '0;
      gnt_q      <= 2'b00;
      done_q     <= 2'b00;
      timeout_q  <= 1'b0;
      busy_q     <= 1'b0;
      f_rst_q    <= 1'b1;
      f_c_q      <= '0;
      f_x_q      <= '0;
      f_i_q      <= '0;
      f_ds_q     <= '0;
      f_rounds_q <= '0;
      res_c_q    <= '0;
      res_x_q    <= '0;
      res_r_q    <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      win_q      <= win_d;
      cnt_q      <= cnt_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      timeout_q  <= timeout_d;
      busy_q     <= busy_d;
      f_rst_q    <= f_rst_d;
      f_c_q      <= f_c_d;
      f_x_q      <= f_x_d;
      f_i_q      <= f_i_d;
      f_ds_q     <= f_ds_d;
      f_rounds_q <= f_rounds_d;
      res_c_q    <= res_c_d;
      res_x_q    <= res_x_d;
      res_r_q    <= res_r_d;
    end
  end

  assign f_c      = f_c_q;
  assign f_x      = f_x_q;
  assign f_i      = f_i_q;
  assign f_ds     = f_ds_q;
  assign f_rounds = f_rounds_q;
  assign f_rst    = f_rst_q;
  assign gnt      = gnt_q;
  assign done     = done_q;
  assign res_c    = res_c_q;
  assign res_x    = res_x_q;
  assign res_r    = res_r_q;
  assign timeout  = timeout_q;
  assign busy     = busy_q;

endmodule

// File: doc/f_scheduler.md
Name: f_scheduler

Overview:
- Time-shares one F permutation core between two requesters: port 0 (absorb engine) and port 1 (squeeze engine).
- Arbitrates round-robin and latches the winner's operands into the core inputs.
- Kicks the core, waits for its done, captures its outputs and returns them to the winner with a one-cycle done pulse.
- A watchdog aborts a hung permutation and flags it.

Parameters:
- CWIDTH, 320, capacity state width (c).
- RWIDTH, 32, rate output width (r).
- XWIDTH, 64, extra state width (x).
- IWIDTH, 128, input block width (i).
- DSWIDTH, 4, domain-separation field width.
- RNDWIDTH, 8, round-count field width.
- TIMEOUT, 1024, maximum BUSY cycles before abort; must be ≥ 2.

Ports:
- clk  in  1  clock; rising-edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  2  request per port; level; held until that port's done.
- c0, c1  in  CWIDTH  capacity operand per port.
- x0, x1  in  XWIDTH  extra-state operand per port.
- i0, i1  in  IWIDTH  input block per port.
- ds0, ds1  in  DSWIDTH  domain bits per port.
- rounds0, rounds1  in  RNDWIDTH  round count per port.
- f_cout  in  CWIDTH  core capacity result.
- f_xout  in  XWIDTH  core extra-state result.
- f_rout  in  RWIDTH  core rate result.
- f_done  in  1  core completion; level.
- f_c  out  CWIDTH  core capacity input.
- f_x  out  XWIDTH  core extra-state input.
- f_i  out  IWIDTH  core block input.
- f_ds  out  DSWIDTH  core domain input.
- f_rounds  out  RNDWIDTH  core round count.
- f_rst  out  1  core reset; active-high; core runs while low.
- gnt  out  2  one-hot grant; valid from KICK through RESP.
- done  out  2  one-cycle completion pulse per port.
- res_c  out  CWIDTH  result capacity.
- res_x  out  XWIDTH  result extra state.
- res_r  out  RWIDTH  result rate.
- timeout  out  1  asserted with done when the op was aborted.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (reset=0, async) values:
  - state=IDLE, last=1 (port 0 wins the first tie).
  - gnt, done, timeout, busy = 0.
  - f_c, f_x, f_i, f_ds, f_rounds, res_c, res_x, res_r = 0.
  - Watchdog counter = 0.
  - f_rst=1.
- All outputs are registered. f_rst is 1 in IDLE, KICK and RESP, and 0 only in BUSY.
- IDLE:
  - If req==0, stay.
  - A single requester wins.
  - If both request, the winner is the port ≠ last.
  - On the transition edge, latch the winner's c/x/i/ds/rounds into f_*, set gnt one-hot, go to KICK.
- KICK: exactly one cycle; f_rst=1, counter cleared; go to BUSY.
- BUSY:
  - f_rst=0; counter increments each cycle.
  - If f_done=1: capture f_cout/f_xout/f_rout into res_*, timeout=0, go to RESP.
  - Else if counter==TIMEOUT-1: res_* unchanged, timeout=1, go to RESP.
  - If f_done arrives on the same cycle as the timeout limit, f_done wins.
- RESP:
  - One cycle; done[winner]=1, f_rst=1, last=winner.
  - Next cycle: state=IDLE, gnt=0, done=0, timeout=0.
- Latency: req seen in IDLE at cycle T → gnt at T+1 → core released (f_rst=0) at T+2 → f_done at cycle D → done pulse at D+1. The minimum total is 4 cycles.
- res_* hold their value until the next successful capture; they stay valid after done.
- f_* operand outputs hold the last latched operands while idle.
- Requester deasserting req mid-operation: the operation still completes and done still pulses.
- A req still high in the IDLE cycle after done is treated as a new request.
- A req arriving during KICK/BUSY/RESP is ignored until IDLE, so there is no starvation: the port waits at most one operation.
- Any operand change during BUSY is ignored (operands were latched).
- reset asserted mid-operation: immediate return to reset values; f_rst=1 aborts the core; no done pulse.

Test Plan:
- Single request: req=01, c0=320'h1, x0=64'h2, i0=128'h3, rounds0=7; model f_done 10 cycles after f_rst falls → gnt=01 at T+1, f_c=1, f_rounds=7, done=01 for exactly one cycle, res_c=f_cout, timeout=0.
- Tie after reset: req=11 held → port 0 served first, then port 1, then port 0 (gnt 01,10,01); each done matches its grant.
- Starvation check: port 1 issues req=1 during port 0's BUSY; port 0 re-requests immediately after its done → port 1 is granted next.
- Watchdog: TIMEOUT=16, f_done held 0 → f_rst falls, 16 BUSY cycles, then done[winner]=1 with timeout=1 and res_* unchanged. Variant: f_done=1 on the 16th BUSY cycle → timeout=0 and results captured.
- Async reset mid-BUSY: pull reset low between clock edges → gnt=0, busy=0, f_rst=1 immediately. After release, req=10 → normal service of port 1 with port 0 first-tie priority restored.
- Request withdrawn: req0 drops one cycle after gnt=01 → done=01 still pulses, and IDLE then remains idle while req=00.
